// File: rtl/scan_select_gen_if.sv
// Control and select bundle between a scan_select_gen and whatever drives it.
// Optional macro SCAN_DIR_EN adds the scan-direction input dir.
interface scan_select_gen_if;
  logic       en;
  logic       mode;
  logic       step;
  logic [3:0] skip_mask;
`ifdef SCAN_DIR_EN
  logic       dir;
`endif
  logic       sel_a;
  logic       sel_b;
  logic       sel_valid;
  logic       tick;
  logic       wrap;

`ifdef SCAN_DIR_EN
  modport master (output en, mode, step, skip_mask, dir,
                  input  sel_a, sel_b, sel_valid, tick, wrap);
  modport slave  (input  en, mode, step, skip_mask, dir,
                  output sel_a, sel_b, sel_valid, tick, wrap);
`else
  modport master (output en, mode, step, skip_mask,
                  input  sel_a, sel_b, sel_valid, tick, wrap);
  modport slave  (input  en, mode, step, skip_mask,
                  output sel_a, sel_b, sel_valid, tick, wrap);
`endif
endinterface

// File: rtl/scan_select_gen.sv
// Steps a 2-bit decoder select index on a prescaled tick or a manual step edge, skipping masked indices.
// Optional macro SCAN_DIR_EN adds descending scan via the interface's dir input.
module scan_select_gen #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DIV_MAX = 49999
) (
  input  logic             clk,
  input  logic             rst_n,
  scan_select_gen_if.slave bus
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_step_q;
  logic [1:0]       r_idx;
  logic             r_tick;
  logic             r_wrap;
  logic             r_valid;

  logic             w_run;
  logic             w_term;
  logic             w_man_adv;
  logic             w_adv;
  logic             w_desc;
  logic             w_found;
  logic [1:0]       w_try;
  logic [1:0]       w_cand;
  logic [1:0]       w_next_idx;
  logic             w_wrap;
  logic [DIV_W-1:0] w_next_cnt;

  assign w_run     = bus.en & bus.mode;
  assign w_term    = w_run & (r_cnt == DIV_W'(DIV_MAX));
  assign w_man_adv = bus.en & ~bus.mode & bus.step & ~r_step_q;
  assign w_adv     = w_term | w_man_adv;

`ifdef SCAN_DIR_EN
  assign w_desc = bus.dir;
`else
  assign w_desc = 1'b0;
`endif

  // Nearest unmasked index in scan order; offset 4 lands back on the current index.
  always_comb begin
    w_found = 1'b0;
    w_cand  = r_idx;
    w_try   = r_idx;
    for (int k = 4; k >= 1; k--) begin
      w_try = w_desc ? (r_idx - 2'(k)) : (r_idx + 2'(k));
      if (!bus.skip_mask[w_try]) begin
        w_found = 1'b1;
        w_cand  = w_try;
      end
    end
  end

  always_comb begin
    w_next_idx = r_idx;
    w_wrap     = 1'b0;
    if (w_adv && w_found) begin
      w_next_idx = w_cand;
      w_wrap     = w_desc ? (w_cand >= r_idx) : (w_cand <= r_idx);
    end
  end

  always_comb begin
    w_next_cnt = '0;
    if (w_run && !w_term) w_next_cnt = r_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_step_q <= 1'b0;
      r_idx    <= 2'd0;
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_cnt    <= w_next_cnt;
      r_step_q <= bus.step;
      r_idx    <= w_next_idx;
      r_tick   <= w_term;
      r_wrap   <= w_wrap;
      r_valid  <= ~bus.skip_mask[w_next_idx];
    end
  end

  assign bus.sel_a     = r_idx[1];
  assign bus.sel_b     = r_idx[0];
  assign bus.sel_valid = r_valid;
  assign bus.tick      = r_tick;
  assign bus.wrap      = r_wrap;

endmodule

// File: tb/tb_scan_select_gen.sv
// Directed and randomized bench for scan_select_gen against a cycle reference model.
module tb_scan_select_gen;

  localparam int unsigned DIV_W   = 16;
  localparam int unsigned DIV_MAX = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  scan_select_gen_if bus();

  scan_select_gen #(.DIV_W(DIV_W), .DIV_MAX(DIV_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int m_cnt;
  int m_idx;
  bit m_stepq;
  bit m_tick;
  bit m_wrap;
  bit m_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_stepq = 0;
    m_tick = 0; m_wrap = 0; m_valid = 0;
  endtask

  // Applies the behavioural rules for one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit desc, auto_adv, man_adv, found;
    int nxt, c;
    if (!rst_n) begin model_reset(); return; end
    desc = 0;
`ifdef SCAN_DIR_EN
    desc = bus.dir;
`endif
    auto_adv = bus.en && bus.mode && (m_cnt == int'(DIV_MAX));
    man_adv  = bus.en && !bus.mode && bus.step && !m_stepq;
    nxt = m_idx; found = 0;
    if (auto_adv || man_adv)
      for (int k = 1; k <= 4; k++)
        if (!found) begin
          c = desc ? (m_idx - k + 8) % 4 : (m_idx + k) % 4;
          if (!bus.skip_mask[c]) begin nxt = c; found = 1; end
        end
    m_tick  = auto_adv;
    m_wrap  = found && (desc ? (nxt >= m_idx) : (nxt <= m_idx));
    m_idx   = nxt;
    m_valid = !bus.skip_mask[nxt];
    if (bus.en && bus.mode) m_cnt = (m_cnt == int'(DIV_MAX)) ? 0 : m_cnt + 1;
    else                    m_cnt = 0;
    m_stepq = bus.step;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".idx"},   {30'd0, bus.sel_a, bus.sel_b}, 32'(m_idx));
    check({tag, ".valid"}, 32'(bus.sel_valid), 32'(m_valid));
    check({tag, ".tick"},  32'(bus.tick), 32'(m_tick));
    check({tag, ".wrap"},  32'(bus.wrap), 32'(m_wrap));
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs(tag);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;
  endtask

  int ticks;
  int changes;
  int prev;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.mode = 1'b0; bus.step = 1'b0; bus.skip_mask = 4'h0;
`ifdef SCAN_DIR_EN
    bus.dir = 1'b0;
`endif
    model_reset();
    #2;
    check_outputs("reset_async");
    @(negedge clk);
    do_reset();

    // auto scan, no mask
    bus.en = 1'b1; bus.mode = 1'b1;
    run(20, "auto_plain");

    // alternate-index mask
    bus.skip_mask = 4'b0101;
    run(16, "auto_mask5");

    // manual steps: three long pulses from index 0
    do_reset();
    bus.skip_mask = 4'h0; bus.mode = 1'b0;
    changes = 0;
    for (int p = 0; p < 3; p++) begin
      bus.step = 1'b1;
      for (int i = 0; i < 10; i++) begin
        prev = {bus.sel_a, bus.sel_b};
        run(1, "manual_hi");
        if ({bus.sel_a, bus.sel_b} != prev) changes++;
      end
      bus.step = 1'b0;
      run(5, "manual_lo");
    end
    check("manual_adv_count", 32'(changes), 32'd3);
    check("manual_final_idx", {30'd0, bus.sel_a, bus.sel_b}, 32'd3);

    // everything masked: ticks continue, index frozen
    do_reset();
    bus.mode = 1'b1; bus.skip_mask = 4'hF;
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      run(1, "auto_allmask");
      if (bus.tick) ticks++;
    end
    check("allmask_ticks", 32'(ticks), 32'd3);

    // async reset mid-count with index 2
    bus.skip_mask = 4'h0;
    do_reset();
    run(9, "pre_async");
    check("pre_async_idx", {30'd0, bus.sel_a, bus.sel_b}, 32'd2);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run(3, "post_rst");
    run(1, "post_rst_tick");
    check("post_rst_tick_seen", 32'(bus.tick), 32'd1);
    check("post_rst_idx", {30'd0, bus.sel_a, bus.sel_b}, 32'd1);

`ifdef SCAN_DIR_EN
    // descending scan
    do_reset();
    bus.dir = 1'b1;
    run(20, "auto_desc");
`endif

    // randomized operation
    for (int i = 0; i < 400; i++) begin
      bus.en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
      bus.step = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) bus.skip_mask = 4'($urandom_range(0, 15));
`ifdef SCAN_DIR_EN
      bus.dir = 1'($urandom_range(0, 1));
`endif
      run(1, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_select_gen.md
Name: scan_select_gen

Overview:
- Sequential source for the select inputs (a, b) of the 2-to-4 decoder stage.
- Steps a 2-bit index through 0..3, either on a prescaled tick or on a manual step pulse.
- Masked indices are skipped.
- Typical use: 4-digit display scanning, where the decoder's one-hot outputs enable the digits.

Parameters:
- DIV_W, 16, prescaler counter width.
- DIV_MAX, 49999, terminal count. Tick period is DIV_MAX+1 clocks. Must be ≤ 2^DIV_W-1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable
- mode  in  1  1 = auto (prescaler-driven), 0 = manual (step-driven)
- step  in  1  manual advance request, level input, edge-detected internally
- skip_mask  in  4  bit i = 1 skips index i
- sel_a  out  1  index bit 1 (MSB), drives decoder input a
- sel_b  out  1  index bit 0 (LSB), drives decoder input b
- sel_valid  out  1  current index not masked
- tick  out  1  one-cycle pulse per prescaler terminal count
- wrap  out  1  one-cycle pulse when an advance wraps the scan

Behaviour:
- Reset (async assert, sync release): prescaler=0, index=0, step_q=0; sel_a=sel_b=0, sel_valid=0, tick=0, wrap=0.
- All outputs are registered; no combinational input-to-output paths.
- Prescaler:
  - Counts only while en=1 and mode=1.
  - Otherwise it is cleared to 0 every cycle.
  - At cnt==DIV_MAX it reloads 0, and tick=1 on the following cycle (registered at the same edge).
  - tick=0 in all other cycles.
- Step edge detect: step_q<=step every cycle, regardless of en.
  - Manual advance when en=1, mode=0, step=1 and step_q=0.
  - Holding step high gives exactly one advance.
- Advance event = auto tick condition, or manual advance. Only one source is possible per cycle, because mode selects.
- Next index on advance:
  - First unmasked candidate among idx+1, idx+2, idx+3, idx+4, taken mod 4 (idx+4 is the current index itself).
  - If all four bits of skip_mask are 1: index holds, wrap=0.
- Timing: the index updates at the same edge that registers tick. New sel_a/sel_b and tick are visible in the same cycle, 1 clock after the terminal count or after the step edge is sampled.
- wrap = 1 for one cycle when an advance produces new index ≤ old index (ascending). With exactly one unmasked index, every advance pulses wrap.
- sel_valid is registered every cycle as ~skip_mask[next_index]. If the mask changes while holding, sel_valid follows one clock later; the index does not move until the next advance.
- en=0: index held, no tick, no wrap, step edges ignored (step_q still tracks step).
- Mode change mid-count: prescaler restarts from 0 on re-entry to auto; the index is unaffected.
- Reset mid-operation: immediate return to reset values. The first post-reset auto tick arrives DIV_MAX+1 clocks after en=1, mode=1 are seen.

Optional Feature:
- Macro SCAN_DIR_EN.
- Defined:
  - Adds input port dir (1 bit). dir=1 scans descending: candidates idx-1, idx-2, idx-3, idx-4 mod 4.
  - wrap then pulses when new index ≥ old index.
  - dir is sampled on the advance cycle only.
- Not defined: port dir is absent; ascending only; behaviour exactly as above.

Test Plan:
- Sim with DIV_MAX=3, skip_mask=0, en=1, mode=1.
  - Required: tick every 4 clocks; (sel_a,sel_b) sequence 00→01→10→11→00.
  - Required: wrap only on the 11→00 advance; sel_valid=1 throughout.
- skip_mask=4'b0101, auto.
  - Required: index sequence 1→3→1→3; wrap on each 3→1; sel_valid=1.
- mode=0, step held high 10 clocks then low, repeated three times.
  - Required: exactly three advances 0→1→2→3, each 1 clock after the step rise; no tick.
- skip_mask=4'hF, auto.
  - Required: tick still pulses; index holds at 0; sel_valid=0; wrap never asserts.
- Index=2 mid-count, rst_n pulsed low asynchronously between edges.
  - Required: outputs 0 immediately.
  - Required: after release, first tick after 4 clocks, index→1.
- With SCAN_DIR_EN, dir=1, mask=0.
  - Required: sequence 0→3→2→1→0; wrap on the 0→3 advance.
